adder_axis_arb: RTL and testbench



---
 rtl/adder_axis_arb.sv | 181 ++++++++++++++++++
 tb/tb_adder_axis_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_axis_arb.sv
// Round-robin arbiter sharing one AXI-Stream pipelined adder between N_REQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module adder_axis_arb #(
   parameter int N_REQ   = 4,
   parameter int IN_W    = 8,
   parameter int OUT_W   = 9,
   parameter int MAX_OUT = 4
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [N_REQ*2*IN_W-1:0] req_tdata,
   input  logic [N_REQ-1:0]        req_tvalid,
   output logic [N_REQ-1:0]        req_tready,
   output logic [N_REQ*OUT_W-1:0]  rsp_tdata,
   output logic [N_REQ-1:0]        rsp_tvalid,
   input  logic [N_REQ-1:0]        rsp_tready,
   output logic [IN_W-1:0]         add1_tdata,
   output logic                    add1_tvalid,
   input  logic                    add1_tready,
   output logic [IN_W-1:0]         add2_tdata,
   output logic                    add2_tvalid,
   input  logic                    add2_tready,
   input  logic [OUT_W-1:0]        sum_tdata,
   input  logic                    sum_tvalid,
   output logic                    sum_tready
);
   localparam int TW = $clog2(N_REQ);
   localparam int AW = $clog2(MAX_OUT);
   localparam int OW = AW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q, state_d;

   logic [IN_W-1:0] op1_q, op2_q;
   logic            sent1_q, sent2_q, sent1_d, sent2_d;
   logic [TW-1:0]   tag_q [MAX_OUT];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]   outst_q, outst_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
   logic [TW-1:0]   last_q;
   logic [TW-1:0]   cand;
`endif

   logic [IN_W-1:0] op1_a [N_REQ];
   logic [IN_W-1:0] op2_a [N_REQ];
   logic            gnt_vld;
   logic [TW-1:0]   gnt_idx;
   logic [TW-1:0]   head;
   logic            accept, hs1, hs2, rsp_hs, empty;

   for (genvar i = 0; i < N_REQ; i++) begin : g_ops
      assign op1_a[i] = req_tdata[i*2*IN_W +: IN_W];
      assign op2_a[i] = req_tdata[i*2*IN_W + IN_W +: IN_W];
   end

   // Arbitration: loops run downward so the last match written is the winner.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (req_tvalid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = TW'(k);
         end
      end
`else
      cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = TW'((int'(last_q) + k) % N_REQ);
         if (req_tvalid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
`endif
      if (outst_q >= OW'(MAX_OUT)) gnt_vld = 1'b0;
   end

   assign accept = aresetn && (state_q == IDLE) && gnt_vld;
   assign hs1    = add1_tvalid & add1_tready;
   assign hs2    = add2_tvalid & add2_tready;
   assign empty  = (outst_q == '0);
   assign head   = tag_q[rd_ptr_q];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sent1_d = sent1_q;
      sent2_d = sent2_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ISSUE;
               sent1_d = 1'b0;
               sent2_d = 1'b0;
            end
         end
         ISSUE: begin
            sent1_d = sent1_q | hs1;
            sent2_d = sent2_q | hs2;
            if (sent1_d && sent2_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      req_tready  = '0;
      add1_tvalid = 1'b0;
      add2_tvalid = 1'b0;
      if (aresetn) begin
         case (state_q)
            IDLE:    if (gnt_vld) req_tready[gnt_idx] = 1'b1;
            ISSUE: begin
               add1_tvalid = !sent1_q;
               add2_tvalid = !sent2_q;
            end
            default: ;
         endcase
      end
   end

   assign add1_tdata = op1_q;
   assign add2_tdata = op2_q;

   // A result with no tag outstanding is never accepted.
   always_comb begin
      rsp_tvalid = '0;
      sum_tready = 1'b0;
      if (aresetn && !empty) begin
         rsp_tvalid[head] = sum_tvalid;
         sum_tready       = rsp_tready[head];
      end
   end

   assign rsp_hs    = sum_tvalid & sum_tready;
   assign rsp_tdata = {N_REQ{sum_tdata}};

   always_comb begin
      outst_d = outst_q;
      if (accept && !rsp_hs)      outst_d = outst_q + 1'b1;
      else if (!accept && rsp_hs) outst_d = outst_q - 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         sent1_q  <= 1'b1;
         sent2_q  <= 1'b1;
         op1_q    <= '0;
         op2_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         outst_q  <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
         last_q   <= TW'(N_REQ-1);
`endif
      end else begin
         state_q <= state_d;
         sent1_q <= sent1_d;
         sent2_q <= sent2_d;
         outst_q <= outst_d;
         if (accept) begin
            op1_q    <= op1_a[gnt_idx];
            op2_q    <= op2_a[gnt_idx];
            wr_ptr_q <= wr_ptr_q + 1'b1;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            last_q   <= gnt_idx;
`endif
         end
         if (rsp_hs) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (accept) tag_q[wr_ptr_q] <= gnt_idx;
   end

endmodule

// File: tb/tb_adder_axis_arb.sv
// Bench for adder_axis_arb: the bench plays the adder and all requesters, and checks
// every cycle against a queue-based model of grants, operand issue and result routing.
module tb_adder_axis_arb;
   localparam int N  = 4;
   localparam int IW = 8;
   localparam int OW = 9;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   logic [N*2*IW-1:0] req_tdata;
   logic [N-1:0]      req_tvalid, req_tready, rsp_tvalid, rsp_tready;
   logic [N*OW-1:0]   rsp_tdata;
   logic [IW-1:0]     add1_tdata, add2_tdata;
   logic              add1_tvalid, add1_tready, add2_tvalid, add2_tready;
   logic [OW-1:0]     sum_tdata;
   logic              sum_tvalid, sum_tready;

   adder_axis_arb #(.N_REQ(N), .IN_W(IW), .OUT_W(OW), .MAX_OUT(MO)) dut (
      .aclk(clk), .aresetn(aresetn),
      .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
      .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
      .add1_tdata(add1_tdata), .add1_tvalid(add1_tvalid), .add1_tready(add1_tready),
      .add2_tdata(add2_tdata), .add2_tvalid(add2_tvalid), .add2_tready(add2_tready),
      .sum_tdata(sum_tdata), .sum_tvalid(sum_tvalid), .sum_tready(sum_tready)
   );

   int checks = 0;
   int errors = 0;

   // Model state: tag order, expected sums, current operation, adder queues
   int  last_m;
   bit  busy_m, s1_m, s2_m;
   int  cur_a, cur_b;
   int  tagq[$];
   int  expsq[$];
   int  a1q[$], a2q[$], sumq[$];
   bit  sum_en;

   // Per-cycle observations for the directed sequences
   int  acc_g, rsp_ch, rsp_dat;
   bit  hs1_o, hs2_o;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ADDER_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (v[k]) return k;
`else
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
      return -1;
   endfunction

   // One clock: entered and left at the negedge; checks and model update happen before the posedge.
   task automatic cycle();
      logic [N-1:0] er, ev;
      logic         e1, e2, est;
      int           g, h;
      sum_tvalid = sum_en && (sumq.size() > 0);
      sum_tdata  = (sumq.size() > 0) ? OW'(sumq[0]) : '0;
      #2;
      er = '0; ev = '0; e1 = 1'b0; e2 = 1'b0; est = 1'b0; g = -1; h = -1;
      acc_g = -1; rsp_ch = -1; hs1_o = 1'b0; hs2_o = 1'b0;
      if (aresetn) begin
         if (!busy_m && tagq.size() < MO) begin
            g = pick(req_tvalid, last_m);
            if (g >= 0) er[g] = 1'b1;
         end
         e1 = busy_m && !s1_m;
         e2 = busy_m && !s2_m;
         if (tagq.size() > 0) begin
            h     = tagq[0];
            ev[h] = sum_tvalid;
            est   = rsp_tready[h];
         end
      end
      chk("req_tready", req_tready, er);
      chk("add1_tvalid", add1_tvalid, e1);
      chk("add2_tvalid", add2_tvalid, e2);
      chk("rsp_tvalid", rsp_tvalid, ev);
      chk("sum_tready", sum_tready, est);
      if (e1) chk("add1_tdata", add1_tdata, cur_a);
      if (e2) chk("add2_tdata", add2_tdata, cur_b);
      if (ev != '0) chk("rsp_tdata", rsp_tdata[h*OW +: OW], sum_tdata);
      if (!aresetn) begin
         busy_m = 1'b0; s1_m = 1'b1; s2_m = 1'b1; last_m = N-1;
         tagq.delete(); expsq.delete(); a1q.delete(); a2q.delete(); sumq.delete();
      end else begin
         if (est && sum_tvalid) begin
            rsp_ch  = h;
            rsp_dat = sumq[0];
            chk("rsp_sum", sumq[0], expsq[0]);
            void'(tagq.pop_front());
            void'(expsq.pop_front());
            void'(sumq.pop_front());
         end
         if (e1 && add1_tready) begin hs1_o = 1'b1; s1_m = 1'b1; a1q.push_back(int'(add1_tdata)); end
         if (e2 && add2_tready) begin hs2_o = 1'b1; s2_m = 1'b1; a2q.push_back(int'(add2_tdata)); end
         if (busy_m && s1_m && s2_m) busy_m = 1'b0;
         if (g >= 0) begin
            acc_g  = g;
            cur_a  = int'(req_tdata[g*2*IW +: IW]);
            cur_b  = int'(req_tdata[g*2*IW + IW +: IW]);
            tagq.push_back(g);
            expsq.push_back((cur_a + cur_b) % (1 << OW));
            last_m = g;
            busy_m = 1'b1; s1_m = 1'b0; s2_m = 1'b0;
         end
         while (a1q.size() > 0 && a2q.size() > 0)
            sumq.push_back((a1q.pop_front() + a2q.pop_front()) % (1 << OW));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      req_tvalid = '0; rsp_tready = '1; add1_tready = 1'b1; add2_tready = 1'b1; sum_en = 1'b1;
      for (int n = 0; n < 60 && (tagq.size() > 0 || busy_m); n++) cycle();
      chk("drain_empty", tagq.size(), 0);
   endtask

   typedef struct { int r; int a; int b; int exp; } vec_t;
   vec_t tv[6];
   int   exp_ord[5];
   int   ord[$];
   int   nacc, h1, h2;
   bit   got;

   initial begin
      tv[0] = '{2, 3, 5, 8};
      tv[1] = '{0, 255, 255, 510};
      tv[2] = '{3, 0, 0, 0};
      tv[3] = '{1, 200, 100, 300};
      tv[4] = '{2, 128, 128, 256};
      tv[5] = '{0, 1, 254, 255};
`ifdef ADDER_ARB_FIXED_PRIO_EN
      exp_ord = '{0, 0, 0, 0, 0};
`else
      exp_ord = '{0, 1, 2, 3, 0};
`endif
      aresetn = 1'b0; req_tdata = '0; req_tvalid = '0; rsp_tready = '0;
      add1_tready = 1'b0; add2_tready = 1'b0; sum_tvalid = 1'b0; sum_tdata = '0; sum_en = 1'b1;
      last_m = N-1; busy_m = 1'b0; s1_m = 1'b1; s2_m = 1'b1; cur_a = 0; cur_b = 0;
      @(negedge clk);
      cycle(); cycle();
      aresetn = 1'b1;
      chk("reset_add1_tdata", add1_tdata, 0);
      chk("reset_add2_tdata", add2_tdata, 0);
      cycle();

      // Grant order with all requesters continuously valid, operands (i, i)
      for (int i = 0; i < N; i++) begin
         req_tdata[i*2*IW +: IW]      = IW'(i);
         req_tdata[i*2*IW + IW +: IW] = IW'(i);
      end
      req_tvalid = '1; add1_tready = 1'b1; add2_tready = 1'b1; rsp_tready = '1;
      for (int n = 0; n < 40 && ord.size() < 5; n++) begin
         cycle();
         if (acc_g >= 0) ord.push_back(acc_g);
      end
      chk("order_count", ord.size(), 5);
      for (int k = 0; k < 5 && k < ord.size(); k++) chk("grant_order", ord[k], exp_ord[k]);
      drain();

      // Single-request vectors
      for (int i = 0; i < 6; i++) begin
         req_tdata = '0;
         req_tdata[tv[i].r*2*IW +: IW]      = IW'(tv[i].a);
         req_tdata[tv[i].r*2*IW + IW +: IW] = IW'(tv[i].b);
         req_tvalid = '0;
         req_tvalid[tv[i].r] = 1'b1;
         got = 1'b0;
         for (int n = 0; n < 40 && !got; n++) begin
            cycle();
            if (acc_g >= 0) begin
               req_tvalid = '0;
               chk("tv_grant", acc_g, tv[i].r);
               chk("tv_add1", {add1_tvalid, add1_tdata}, {1'b1, IW'(tv[i].a)});
               chk("tv_add2", {add2_tvalid, add2_tdata}, {1'b1, IW'(tv[i].b)});
            end
            if (rsp_ch >= 0) begin
               got = 1'b1;
               chk("tv_rsp_ch", rsp_ch, tv[i].r);
               chk("tv_rsp_data", rsp_dat, tv[i].exp);
            end
         end
         chk("tv_done", got, 1);
      end
      drain();

      // Skewed adder readies: op2 ready 3 cycles after op1
      req_tdata = '0;
      req_tdata[1*2*IW +: 2*IW] = 16'h0907;
      req_tdata[3*2*IW +: 2*IW] = 16'h0102;
      req_tvalid = 4'b0010; add1_tready = 1'b1; add2_tready = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin cycle(); got = (acc_g == 1); end
      chk("skew_accept", got, 1);
      req_tvalid = 4'b1000;
      h1 = 0; h2 = 0;
      for (int n = 0; n < 3; n++) begin cycle(); h1 += int'(hs1_o); h2 += int'(hs2_o); end
      add2_tready = 1'b1;
      cycle(); h1 += int'(hs1_o); h2 += int'(hs2_o);
      chk("skew_idle_after_op2", req_tready, 4'b1000);
      chk("skew_op1_once", h1, 1);
      chk("skew_op2_once", h2, 1);
      cycle();
      drain();

      // Back-pressure: results held, only MAX_OUT accepts
      for (int i = 0; i < N; i++) req_tdata[i*2*IW +: 2*IW] = 16'($urandom);
      req_tvalid = '1; rsp_tready = '0; nacc = 0;
      for (int n = 0; n < 14; n++) begin cycle(); if (acc_g >= 0) nacc++; end
      chk("bp_accepts", nacc, MO);
      chk("bp_ready_low", req_tready, 0);
      rsp_tready = '1; cycle();
      chk("bp_pop", rsp_ch >= 0, 1);
      rsp_tready = '0; nacc = 0;
      for (int n = 0; n < 10; n++) begin cycle(); if (acc_g >= 0) nacc++; end
      chk("bp_one_more", nacc, 1);

      // Pop, then simultaneous pop + accept at outstanding MAX_OUT-1
      rsp_tready = '1; cycle();
      chk("sim_first_pop", rsp_ch >= 0, 1);
      cycle();
      chk("sim_accept", acc_g >= 0, 1);
      chk("sim_pop", rsp_ch >= 0, 1);
      rsp_tready = '0; nacc = 0;
      for (int n = 0; n < 10; n++) begin cycle(); if (acc_g >= 0) nacc++; end
      chk("sim_count_held", nacc, 1);
      drain();

      // Reset during ISSUE
      req_tvalid = 4'b0100; add1_tready = 1'b0; add2_tready = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin cycle(); got = (acc_g == 2); end
      chk("rst_accept", got, 1);
      cycle();
      aresetn = 1'b0; cycle();
      aresetn = 1'b1;
      chk("rst_add_valids", {add1_tvalid, add2_tvalid}, 0);
      req_tvalid = '1; add1_tready = 1'b1; add2_tready = 1'b1; rsp_tready = '1;
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         cycle();
         if (acc_g >= 0) begin got = 1'b1; chk("rst_first_grant", acc_g, 0); end
      end
      chk("rst_grant_seen", got, 1);
      drain();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         add1_tready = ($urandom_range(0, 3) != 0);
         add2_tready = ($urandom_range(0, 3) != 0);
         rsp_tready  = 4'($urandom);
         sum_en      = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (acc_g == i || !req_tvalid[i]) begin
               req_tvalid[i] = ($urandom_range(0, 2) != 0);
               req_tdata[i*2*IW +: 2*IW] = 16'($urandom);
            end
         end
         cycle();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
